// File: rtl/demux32_8.sv
// Word-to-byte serializer: 32-bit words in, four MSB-first bytes out on clk_4f.
// Latency: first byte one edge after a push into an empty, idle block.
// Backpressure: ready_out drops while the word FIFO holds DEPTH words.
module word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module demux32_8 #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [31:0]              data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [7:0]               data_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        push;
  logic        pop;
  logic [31:0] head_dat;
  logic [31:0] shreg;
  logic [1:0]  byte_idx;

  // Full check uses the pre-edge count, so a full FIFO refuses even on a pop edge.
  assign ready_out = reset && (fifo_count < CW'(DEPTH));
  assign push      = valid_in && ready_out;

  word_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk_4f),
    .rst_n    (reset),
    .push     (push),
    .push_dat (data_in),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    pop       = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Last byte on the wire: chain straight into the next word if one is waiting.
        if (byte_idx == 2'd3) begin
          if (fifo_count != '0) pop = 1'b1;
          else                  state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // byte_idx tracks which byte of the current word is on data_out.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_idx  <= 2'd0;
    end else if (pop) begin
      shreg     <= {head_dat[23:0], 8'h00};
      data_out  <= head_dat[31:24];
      valid_out <= 1'b1;
      byte_idx  <= 2'd0;
    end else if (state == SHIFT && byte_idx != 2'd3) begin
      shreg     <= {shreg[23:0], 8'h00};
      data_out  <= shreg[31:24];
      valid_out <= 1'b1;
      byte_idx  <= byte_idx + 2'd1;
    end else begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_idx  <= 2'd0;
    end
  end
endmodule

// File: tb/tb_demux32_8.sv
// Directed bench for demux32_8 (DEPTH=4): latency, back-to-back, overflow, reset truncation, wrap.
module tb_demux32_8;
  localparam int DEPTH = 4;

  logic        clk_4f;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  bit sb_en  = 0;
  logic [7:0] exp_q[$];

  demux32_8 #(.DEPTH(DEPTH)) dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .fifo_count (fifo_count)
  );

  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  // Advance one edge; with the scoreboard on, every valid byte must match the reference queue.
  task automatic tick_chk();
    logic [7:0] e;
    tick();
    if (sb_en && valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra_byte: observed %0h expected no byte", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_byte", {24'h0, data_out}, {24'h0, e});
      end
    end
  endtask

  task automatic queue_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
  endtask

  task automatic run_single(input logic [31:0] w);
    data_in  = w;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("single_cnt_after_push", {29'h0, fifo_count}, 32'd1);
    chk("single_vld_before", {31'h0, valid_out}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("single_byte", {24'h0, data_out}, {24'h0, w[31-8*b -: 8]});
      chk("single_vld", {31'h0, valid_out}, 32'd1);
    end
    tick();
    chk("single_idle_vld", {31'h0, valid_out}, 32'd0);
    chk("single_idle_dat", {24'h0, data_out}, 32'h0);
    chk("single_idle_cnt", {29'h0, fifo_count}, 32'd0);
  endtask

  initial begin
    logic [63:0] pair;
    logic [11:0] rdy_exp;
    int          cnt_exp[12];
    logic [31:0] w;
    int          guard;

    reset    = 1'b0;
    data_in  = '0;
    valid_in = 1'b0;
    #2;
    chk("rst_dat", {24'h0, data_out}, 32'h0);
    chk("rst_vld", {31'h0, valid_out}, 32'd0);
    chk("rst_rdy", {31'h0, ready_out}, 32'd0);
    chk("rst_cnt", {29'h0, fifo_count}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("rdy_after_release", {31'h0, ready_out}, 32'd1);

    // Single word, MSB first, one edge after the push.
    run_single(32'hA1B2C3D4);

    // Two words back to back: eight bytes with no bubble.
    pair     = 64'h11223344_55667788;
    data_in  = pair[63:32];
    valid_in = 1'b1;
    tick();
    data_in  = pair[31:0];
    tick();
    valid_in = 1'b0;
    chk("b2b_cnt_push_pop", {29'h0, fifo_count}, 32'd1);
    chk("b2b_byte0", {24'h0, data_out}, 32'h11);
    for (int b = 1; b < 8; b++) begin
      tick();
      chk("b2b_byte", {24'h0, data_out}, {24'h0, pair[63-8*b -: 8]});
      chk("b2b_vld", {31'h0, valid_out}, 32'd1);
    end
    tick();
    chk("b2b_idle_vld", {31'h0, valid_out}, 32'd0);

    // Continuous offer for 12 cycles: FIFO fills, offers at ready_out=0 are dropped.
    rdy_exp = 12'b0100_0101_1111;
    cnt_exp = '{1, 1, 2, 3, 4, 3, 4, 4, 4, 3, 4, 4};
    sb_en   = 1'b1;
    for (int k = 0; k < 12; k++) begin
      w        = 32'h10203040 + 32'h01010101 * (k + 1);
      data_in  = w;
      valid_in = 1'b1;
      chk("fill_rdy", {31'h0, ready_out}, {31'h0, rdy_exp[k]});
      if (rdy_exp[k]) queue_word(w);
      tick_chk();
      chk("fill_cnt", {29'h0, fifo_count}, cnt_exp[k]);
    end
    valid_in = 1'b0;
    guard    = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      tick_chk();
      guard++;
    end
    chk("fill_drained", exp_q.size(), 32'd0);
    tick_chk();
    chk("fill_idle_vld", {31'h0, valid_out}, 32'd0);
    sb_en = 1'b0;

    // Push lands on the edge that pops the only buffered word; then reset mid-word.
    pair     = 64'hCAFEF00D_DEADBEEF;
    data_in  = pair[63:32];
    valid_in = 1'b1;
    tick();
    data_in  = pair[31:0];
    tick();
    valid_in = 1'b0;
    chk("pp_cnt_unchanged", {29'h0, fifo_count}, 32'd1);
    chk("pp_byte0", {24'h0, data_out}, 32'hCA);
    for (int b = 1; b < 6; b++) begin
      tick();
      chk("pp_byte", {24'h0, data_out}, {24'h0, pair[63-8*b -: 8]});
    end
    reset = 1'b0;
    #1;
    chk("trunc_dat", {24'h0, data_out}, 32'h0);
    chk("trunc_vld", {31'h0, valid_out}, 32'd0);
    chk("trunc_cnt", {29'h0, fifo_count}, 32'd0);
    chk("trunc_rdy", {31'h0, ready_out}, 32'd0);
    tick();
    chk("trunc_hold_vld", {31'h0, valid_out}, 32'd0);
    reset = 1'b1;
    #1;
    chk("trunc_rdy_release", {31'h0, ready_out}, 32'd1);
    run_single(32'h01020304);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_residual_vld", {31'h0, valid_out}, 32'd0);
    end

    // Random gaps across more than 2*DEPTH words to wrap the pointers.
    sb_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) tick_chk();
      w        = $urandom;
      data_in  = w;
      valid_in = 1'b1;
      guard    = 0;
      while (!ready_out && guard < 100) begin
        tick_chk();
        guard++;
      end
      chk("rand_ready_wait", {31'h0, ready_out}, 32'd1);
      queue_word(w);
      tick_chk();
      valid_in = 1'b0;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      tick_chk();
      guard++;
    end
    chk("rand_drained", exp_q.size(), 32'd0);
    tick_chk();
    chk("rand_idle_vld", {31'h0, valid_out}, 32'd0);
    chk("rand_idle_cnt", {29'h0, fifo_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
